burst_cmd_scheduler: RTL and testbench
======================================

Name: burst_cmd_scheduler

Overview:
- Timing controller between the burst storage/back-end and the DDR5 command path.
- Watches the per-burst state, type and address of every burst slot.
- Issues at most one command (activate, read, write or precharge) per cycle, tagged with the burst index.
- Keeps per-bank open-row and timing state, and schedules open-page, row-hit-first, with round-robin fairness.

Parameters:
- no_of_bursts, 4, number of burst slots observed (power of 2, ≥2).
- T_RCD, 8, cycles from activate to first column command on that bank.
- T_RP, 8, cycles from precharge to next activate on that bank.
- T_RAS, 16, minimum cycles from activate to precharge on that bank.
- T_CCD, 8, minimum cycles between any two column commands (global data bus).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous reset, active low.
- in_burst_state, input, no_of_bursts x burst_states_type, per-slot state. Encodings: empty=0, started_filling=1, almost_done=2, full=3, returning_data=4.
- in_burst_type, input, no_of_bursts x r_type, read=0 / write=1.
- in_burst_address_bank, input, no_of_bursts x 2, bank.
- in_burst_address_bg, input, no_of_bursts x 2, bank group.
- in_burst_address_row, input, no_of_bursts x 16, row.
- out_burst_cmd, output, command (3), none=0, activate=1, read_cmd=2, write_cmd=3, precharge=4.
- out_cmd_index, output, $clog2(no_of_bursts), slot the command belongs to.

Behaviour:
- Reset (rst_n=0 at posedge): out_burst_cmd=none, out_cmd_index=0; all 16 bank entries closed (open=0, row=0); all bank timers, tRAS timers and the CCD timer set to 0; issued[] cleared; rr_ptr=0. Reset mid-command aborts it and the next cycle is none.
- Bank id = {bg, bank} (16 banks). Per bank: open bit, open_row[15:0], bank_timer, ras_timer. Global: ccd_timer. All timers are saturating down-counters, decrementing by 1 per cycle while nonzero.
- Eligible slot i: state==full and issued[i]==0. issued[i] sets when a read_cmd/write_cmd is issued for i, and clears when state==empty is sampled.
- Per-slot candidate command, by bank status:
  - Bank open and row == open_row: column command. Gated by bank_timer==0 and ccd_timer==0. read_cmd if type==read, else write_cmd.
  - Bank open and row differs: precharge. Gated by bank_timer==0 and ras_timer==0.
  - Bank closed: activate. Gated by bank_timer==0.
- Pick per cycle (combinational from registered state; output registered, so 1-cycle latency from inputs to command):
  - Priority 1: ready column commands. Lowest index at or after rr_ptr (circular scan).
  - Priority 2: ready activate/precharge. Same circular scan from rr_ptr.
  - Precharge is suppressed for a bank while any eligible slot row-hits that bank (hit-first protects the open row).
  - If two eligible slots share a closed bank, only the winning slot's activate is issued. The other slot re-evaluates next cycle.
- Nothing ready: out_burst_cmd=none. A command is valid for exactly one cycle; back-to-back commands on consecutive cycles are allowed.
- Issue updates, same posedge as the output register:
  - activate: open=1, open_row=row, bank_timer=T_RCD, ras_timer=T_RAS.
  - precharge: open=0, bank_timer=T_RP.
  - read/write: ccd_timer=T_CCD, issued set.
  - rr_ptr = winner+1, mod no_of_bursts (wrap-around).
- Timer loaded on the issue cycle: the next same-class command is legal exactly N cycles later (activate at cycle t allows column at t+T_RCD).
- Slot leaving full before its command is issued: dropped silently, no command emitted.
- All slots empty: output none continuously; bank state retained (open page).

Test Plan:
- Reset with rst_n=0 for 2 cycles mid-activity -> out_burst_cmd=0 at every posedge during and the cycle after; a subsequent full read to bg=1,bank=2,row=0x00A5 produces activate before any column command.
- Slot0 full read, bg=0,bank=0,row=0x0010, bank closed -> activate idx0 at t; read_cmd idx0 at t+8; no other command; idx0 never reissued until its state goes empty and then full again.
- Slots 0 and 1 full writes to the same open bank and row -> write_cmd idx0 at t, write_cmd idx1 at t+8 (T_CCD); no command in between.
- Bank 3 open on row 0x0001 since t0; slot2 full read, row 0x0002 -> precharge idx2 not before t0+16; activate at precharge+8; read at activate+8.
- Slot0 row-miss and slot1 row-hit on the same bank, both full -> read_cmd idx1 issued first; precharge idx0 only after slot1 issued.
- rr_ptr=3, slots 0 and 3 both ready activates on different banks -> idx3 first, then idx0 on the next cycle (wrap-around).

Source files
------------

// File: rtl/burst_cmd_scheduler.sv
// burst_cmd_scheduler: open-page, row-hit-first DDR5 command scheduler.
// Ports: clk, rst_n (sync, active low); per-slot state/type/bank/bg/row in;
//        registered out_burst_cmd and out_cmd_index (one command per cycle).
module burst_cmd_scheduler #(
  parameter int no_of_bursts = 4,
  parameter int T_RCD = 8,
  parameter int T_RP  = 8,
  parameter int T_RAS = 16,
  parameter int T_CCD = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [no_of_bursts-1:0][2:0]        in_burst_state,
  input  logic [no_of_bursts-1:0]             in_burst_type,
  input  logic [no_of_bursts-1:0][1:0]        in_burst_address_bank,
  input  logic [no_of_bursts-1:0][1:0]        in_burst_address_bg,
  input  logic [no_of_bursts-1:0][15:0]       in_burst_address_row,
  output logic [2:0]                          out_burst_cmd,
  output logic [$clog2(no_of_bursts)-1:0]     out_cmd_index
);

  localparam int IW = $clog2(no_of_bursts);
  localparam int TW = 8;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_RD   = 3'd2,
    CMD_WR   = 3'd3,
    CMD_PRE  = 3'd4
  } cmd_e;

  localparam logic [2:0] ST_EMPTY = 3'd0;
  localparam logic [2:0] ST_FULL  = 3'd3;

  logic [15:0]   bank_open;
  logic [15:0]   open_row   [16];
  logic [TW-1:0] bank_timer [16];
  logic [TW-1:0] ras_timer  [16];
  logic [TW-1:0] ccd_timer;
  logic [no_of_bursts-1:0] issued;
  logic [IW-1:0] rr_ptr;

  logic [3:0] bid [no_of_bursts];
  logic [no_of_bursts-1:0] elig;
  logic [no_of_bursts-1:0] hit;
  logic [no_of_bursts-1:0] col_rdy;
  logic [no_of_bursts-1:0] oth_rdy;
  logic [15:0] hit_bank;

  always_comb begin
    hit_bank = '0;
    for (int i = 0; i < no_of_bursts; i++) begin
      bid[i]  = {in_burst_address_bg[i], in_burst_address_bank[i]};
      elig[i] = (in_burst_state[i] == ST_FULL) && !issued[i];
      hit[i]  = elig[i] && bank_open[bid[i]] &&
                (in_burst_address_row[i] == open_row[bid[i]]);
      if (hit[i]) hit_bank[bid[i]] = 1'b1;
    end
    for (int i = 0; i < no_of_bursts; i++) begin
      col_rdy[i] = hit[i] && (bank_timer[bid[i]] == '0) &&
                   (ccd_timer == '0);
      // Row miss on an open bank waits for tRAS and for any
      // pending row hit on that bank (open row is protected).
      oth_rdy[i] = elig[i] && !hit[i] && (bank_timer[bid[i]] == '0) &&
                   (!bank_open[bid[i]] ||
                    ((ras_timer[bid[i]] == '0) && !hit_bank[bid[i]]));
    end
  end

  logic          col_found;
  logic          oth_found;
  logic [IW-1:0] col_win;
  logic [IW-1:0] oth_win;
  logic [IW-1:0] scan;
  logic [IW-1:0] win;
  logic [3:0]    win_bank;
  logic          win_vld;
  cmd_e          win_cmd;

  // Scan from the farthest offset down so the last hit kept is the
  // first slot at or after rr_ptr in circular order.
  always_comb begin
    col_found = 1'b0;
    oth_found = 1'b0;
    col_win   = '0;
    oth_win   = '0;
    scan      = '0;
    for (int k = no_of_bursts - 1; k >= 0; k--) begin
      scan = rr_ptr + IW'(k);
      if (col_rdy[scan]) begin
        col_found = 1'b1;
        col_win   = scan;
      end
      if (oth_rdy[scan]) begin
        oth_found = 1'b1;
        oth_win   = scan;
      end
    end
    win      = col_found ? col_win : oth_win;
    win_vld  = col_found | oth_found;
    win_bank = bid[win];
    if (col_found)
      win_cmd = in_burst_type[win] ? CMD_WR : CMD_RD;
    else
      win_cmd = bank_open[win_bank] ? CMD_PRE : CMD_ACT;
  end

  // Timers hold the cycles still to wait after the issuing edge,
  // so a load of N-1 makes the follow-up legal exactly N cycles on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_burst_cmd <= CMD_NONE;
      out_cmd_index <= '0;
      bank_open     <= '0;
      ccd_timer     <= '0;
      issued        <= '0;
      rr_ptr        <= '0;
      for (int b = 0; b < 16; b++) begin
        open_row[b]   <= '0;
        bank_timer[b] <= '0;
        ras_timer[b]  <= '0;
      end
    end else begin
      out_burst_cmd <= win_vld ? win_cmd : CMD_NONE;
      out_cmd_index <= win_vld ? win : '0;
      if (ccd_timer != '0) ccd_timer <= ccd_timer - 1'b1;
      for (int b = 0; b < 16; b++) begin
        if (bank_timer[b] != '0) bank_timer[b] <= bank_timer[b] - 1'b1;
        if (ras_timer[b] != '0)  ras_timer[b]  <= ras_timer[b] - 1'b1;
      end
      for (int i = 0; i < no_of_bursts; i++) begin
        if (in_burst_state[i] == ST_EMPTY) issued[i] <= 1'b0;
      end
      if (win_vld) begin
        rr_ptr <= win + 1'b1;
        case (win_cmd)
          CMD_ACT: begin
            bank_open[win_bank]  <= 1'b1;
            open_row[win_bank]   <= in_burst_address_row[win];
            bank_timer[win_bank] <= TW'(T_RCD - 1);
            ras_timer[win_bank]  <= TW'(T_RAS - 1);
          end
          CMD_PRE: begin
            bank_open[win_bank]  <= 1'b0;
            bank_timer[win_bank] <= TW'(T_RP - 1);
          end
          default: begin
            ccd_timer   <= TW'(T_CCD - 1);
            issued[win] <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_burst_cmd_scheduler.sv
// tb_burst_cmd_scheduler: directed and random checks of burst_cmd_scheduler
// against a timestamp-based reference model of the scheduling rules.
module tb_burst_cmd_scheduler;

  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int T_RCD = 8;
  localparam int T_RP  = 8;
  localparam int T_RAS = 16;
  localparam int T_CCD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0][2:0]  st;
  logic [N-1:0]       ty;
  logic [N-1:0][1:0]  bk;
  logic [N-1:0][1:0]  bg;
  logic [N-1:0][15:0] row;
  logic [2:0]         cmd;
  logic [IW-1:0]      idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  burst_cmd_scheduler #(
    .no_of_bursts(N), .T_RCD(T_RCD), .T_RP(T_RP),
    .T_RAS(T_RAS), .T_CCD(T_CCD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_burst_state(st),
    .in_burst_type(ty),
    .in_burst_address_bank(bk),
    .in_burst_address_bg(bg),
    .in_burst_address_row(row),
    .out_burst_cmd(cmd),
    .out_cmd_index(idx)
  );

  // Reference model: earliest legal edge numbers per bank and bus.
  bit          m_open   [16];
  logic [15:0] m_row    [16];
  int          m_bank_ok[16];
  int          m_ras_ok [16];
  int          m_ccd_ok;
  bit          m_iss    [N];
  int          m_rr;
  int          t = 0;

  int ta, tr, tp, t0, w1, w2, n, c1, c2, i1, i2, seen;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_slot(int i, int s, int typ, int g, int b, int r);
    st[i]  = 3'(s);
    ty[i]  = 1'(typ);
    bg[i]  = 2'(g);
    bk[i]  = 2'(b);
    row[i] = 16'(r);
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_slot(i, 0, 0, 0, 0, 0);
  endtask

  task automatic model(output logic [31:0] ecmd, output logic [31:0] eidx);
    bit hitb[16];
    bit el[N];
    bit ht[N];
    int b[N];
    bit found;
    int i;
    ecmd = 0;
    eidx = 0;
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        m_open[k] = 0; m_row[k] = 0;
        m_bank_ok[k] = 0; m_ras_ok[k] = 0;
      end
      for (int k = 0; k < N; k++) m_iss[k] = 0;
      m_ccd_ok = 0;
      m_rr = 0;
      return;
    end
    for (int k = 0; k < 16; k++) hitb[k] = 0;
    for (int j = 0; j < N; j++) begin
      b[j]  = int'(bg[j]) * 4 + int'(bk[j]);
      el[j] = (st[j] == 3) && !m_iss[j];
      ht[j] = el[j] && m_open[b[j]] && (row[j] == m_row[b[j]]);
      if (ht[j]) hitb[b[j]] = 1;
    end
    found = 0;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (!found && ht[i] && t >= m_bank_ok[b[i]] && t >= m_ccd_ok) begin
        found = 1; ecmd = ty[i] ? 3 : 2; eidx = i;
      end
    end
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (!found && el[i]) begin
        if (!m_open[b[i]]) begin
          if (t >= m_bank_ok[b[i]]) begin
            found = 1; ecmd = 1; eidx = i;
          end
        end else if (!ht[i] && !hitb[b[i]] && t >= m_bank_ok[b[i]] &&
                     t >= m_ras_ok[b[i]]) begin
          found = 1; ecmd = 4; eidx = i;
        end
      end
    end
    for (int j = 0; j < N; j++) if (st[j] == 0) m_iss[j] = 0;
    if (found) begin
      i = int'(eidx);
      case (ecmd)
        1: begin
          m_open[b[i]] = 1;
          m_row[b[i]] = row[i];
          m_bank_ok[b[i]] = t + T_RCD;
          m_ras_ok[b[i]] = t + T_RAS;
        end
        4: begin
          m_open[b[i]] = 0;
          m_bank_ok[b[i]] = t + T_RP;
        end
        default: begin
          m_ccd_ok = t + T_CCD;
          m_iss[i] = 1;
        end
      endcase
      m_rr = (i + 1) % N;
    end
  endtask

  task automatic step();
    logic [31:0] ecmd, eidx;
    t++;
    model(ecmd, eidx);
    @(posedge clk);
    #1;
    check("cmd", cmd, ecmd);
    check("idx", idx, eidx);
  endtask

  initial begin
    st = '0; ty = '0; bk = '0; bg = '0; row = '0;
    rst_n = 1'b0;
    step();
    step();
    check("rst_cmd", cmd, 0);
    check("rst_idx", idx, 0);
    rst_n = 1'b1;

    // Closed bank: activate then read T_RCD later, no reissue.
    set_slot(0, 3, 0, 0, 0, 'h10);
    ta = -1; tr = -1; n = 0;
    repeat (14) begin
      step();
      if (cmd != 0) n++;
      if (cmd == 1 && idx == 0 && ta < 0) ta = t;
      if (cmd == 2 && idx == 0 && tr < 0) tr = t;
    end
    check("a_gap", tr - ta, T_RCD);
    check("a_cnt", n, 2);
    repeat (6) step();
    set_slot(0, 0, 0, 0, 0, 0);
    step();
    set_slot(0, 3, 0, 0, 0, 'h10);
    n = 0;
    repeat (10) begin
      step();
      if (cmd == 2 && idx == 0) n++;
    end
    check("a_reissue", n, 1);

    // Two writes on the same open row, spaced by T_CCD.
    set_slot(0, 0, 0, 0, 0, 0);
    step();
    set_slot(0, 3, 1, 0, 0, 'h10);
    set_slot(1, 3, 1, 0, 0, 'h10);
    w1 = -1; w2 = -1; n = 0;
    repeat (20) begin
      step();
      if (cmd != 0) begin
        n++;
        if (cmd == 3) begin
          if (w1 < 0) w1 = t;
          else if (w2 < 0) w2 = t;
        end
      end
    end
    check("b_gap", w2 - w1, T_CCD);
    check("b_cmds", n, 2);
    clear_all();
    step();

    // Row miss on bank 3: precharge after tRAS, activate, read.
    set_slot(2, 3, 0, 0, 3, 1);
    t0 = -1;
    repeat (12) begin
      step();
      if (cmd == 1 && idx == 2 && t0 < 0) t0 = t;
    end
    set_slot(2, 0, 0, 0, 0, 0);
    step();
    set_slot(2, 3, 0, 0, 3, 2);
    tp = -1; ta = -1; tr = -1;
    repeat (40) begin
      step();
      if (cmd == 4 && idx == 2 && tp < 0) tp = t;
      if (cmd == 1 && idx == 2 && tp >= 0 && ta < 0) ta = t;
      if (cmd == 2 && idx == 2 && ta >= 0 && tr < 0) tr = t;
    end
    check("c_ras", (t0 >= 0 && tp >= 0 && tp - t0 >= T_RAS), 1);
    check("c_rp", ta - tp, T_RP);
    check("c_rcd", tr - ta, T_RCD);

    // Row hit on slot1 served before row miss precharge for slot0.
    set_slot(2, 0, 0, 0, 0, 0);
    set_slot(0, 3, 0, 0, 3, 5);
    set_slot(1, 3, 0, 0, 3, 2);
    c1 = -1; c2 = -1; i1 = -1; i2 = -1;
    repeat (20) begin
      step();
      if (cmd != 0) begin
        if (c1 < 0) begin c1 = cmd; i1 = idx; end
        else if (c2 < 0) begin c2 = cmd; i2 = idx; end
      end
    end
    check("d_first_cmd", c1, 2);
    check("d_first_idx", i1, 1);
    check("d_second_cmd", c2, 4);
    check("d_second_idx", i2, 0);
    clear_all();
    step();

    // Round robin wrap: rr_ptr at 3 after an activate on slot 2.
    set_slot(2, 3, 0, 2, 0, 7);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      step();
      if (cmd == 1 && idx == 2) seen = 1;
    end
    check("e_setup", seen, 1);
    set_slot(0, 3, 0, 3, 1, 9);
    set_slot(3, 3, 0, 3, 2, 9);
    step();
    check("e_first_cmd", cmd, 1);
    check("e_first_idx", idx, 3);
    step();
    check("e_second_cmd", cmd, 1);
    check("e_second_idx", idx, 0);

    // Reset in the middle of pending column traffic.
    step();
    rst_n = 1'b0;
    step();
    check("f_rst1", cmd, 0);
    clear_all();
    step();
    check("f_rst2", cmd, 0);
    rst_n = 1'b1;
    set_slot(1, 3, 0, 1, 2, 'hA5);
    c1 = -1; i1 = -1;
    for (int k = 0; k < 12 && c1 < 0; k++) begin
      step();
      if (cmd != 0) begin c1 = cmd; i1 = idx; end
    end
    check("f_first_cmd", c1, 1);
    check("f_first_idx", i1, 1);
    repeat (10) step();

    // Random traffic over a few banks and rows.
    clear_all();
    step();
    repeat (1500) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          if (st[i] != 3)
            set_slot(i,
                     ($urandom_range(0, 1) == 1) ? 3 :
                       int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)));
          else
            st[i] = 3'($urandom_range(0, 4));
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
